// File: rtl/scan_pkg.sv
// Shared types and defaults for the CPU scan-chain sequencer.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    FINISH
  } scan_state_e;

  // Shared with the CPU top so the chain length stays in one place.
  localparam int SCAN_CHAIN_LEN_DEFAULT = 24;
  localparam int SCAN_HALF_DEFAULT      = 2;

endpackage

// File: rtl/scan_ctrl_if.sv
// Host-side request/response bundle for scan_ctrl.
interface scan_ctrl_if
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = SCAN_CHAIN_LEN_DEFAULT
);
  logic                 start;
  logic [CHAIN_LEN-1:0] load_data;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] capture_data;

  // Host issues requests and reads the captured word.
  modport master (
    output start, load_data,
    input  busy, done, capture_data
  );

  // Sequencer side.
  modport slave (
    input  start, load_data,
    output busy, done, capture_data
  );
endinterface

// File: rtl/scan_ctrl.sv
// Scan-chain sequencer: shifts a parallel word into the CPU scan chain while
// capturing the previous chain contents. Every output is a register loaded
// from the state being left, so pins trail the FSM by one cycle.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = SCAN_CHAIN_LEN_DEFAULT,
  parameter int HALF      = SCAN_HALF_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  scan_ctrl_if.slave host,
  output logic       scan_clk,
  output logic       scan_en,
  output logic       scan_in,
  input  logic       scan_out
);

  localparam int                BW      = $clog2(CHAIN_LEN + 1);
  localparam logic [BW-1:0]     BITS    = BW'(CHAIN_LEN);
  localparam logic [3:0]        PH_LAST = 4'(HALF - 1);

  if (CHAIN_LEN < 2 || CHAIN_LEN > 64) begin : g_bad_len
    $error("scan_ctrl: CHAIN_LEN must be within 2..64");
  end
  if (HALF < 1 || HALF > 15) begin : g_bad_half
    $error("scan_ctrl: HALF must be within 1..15");
  end

  scan_state_e          state_q;
  logic [CHAIN_LEN-1:0] sr_q;
  logic [BW-1:0]        bitcnt_q;
  logic [3:0]           phcnt_q;
  logic                 cap_bit_q;
  logic                 busy_q;
  logic                 done_q;
  logic [CHAIN_LEN-1:0] capture_q;
  logic                 scan_clk_q;
  logic                 scan_en_q;
  logic                 scan_in_q;

  // Sequencer FSM with registered pin and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bitcnt_q   <= '0;
      phcnt_q    <= '0;
      cap_bit_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      capture_q  <= '0;
      scan_clk_q <= 1'b0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
    end else begin
      busy_q     <= (state_q != IDLE);
      done_q     <= (state_q == FINISH);
      scan_clk_q <= (state_q == SHIFT_HI);
      scan_en_q  <= (state_q inside {SETUP, SHIFT_LO, SHIFT_HI});
      // scan_in only moves while the scan clock is low; held through the high
      // phase so the chain sees a stable bit on the rising edge.
      if (state_q inside {SETUP, SHIFT_LO}) scan_in_q <= sr_q[0];
      else if (state_q != SHIFT_HI)         scan_in_q <= 1'b0;
      if (state_q == FINISH) capture_q <= sr_q;

      case (state_q)
        IDLE: begin
          if (host.start) begin
            sr_q     <= host.load_data;
            bitcnt_q <= BITS;
            phcnt_q  <= PH_LAST;
            state_q  <= SETUP;
          end
        end
        SETUP: state_q <= SHIFT_LO;
        SHIFT_LO: begin
          if (phcnt_q == 4'd0) begin
            cap_bit_q <= scan_out;
            phcnt_q   <= PH_LAST;
            state_q   <= SHIFT_HI;
          end else begin
            phcnt_q <= phcnt_q - 4'd1;
          end
        end
        SHIFT_HI: begin
          if (phcnt_q == 4'd0) begin
            // Captured tail bit enters at the MSB; after CHAIN_LEN steps sr
            // holds the old chain with its first-out bit at [0].
            sr_q     <= {cap_bit_q, sr_q[CHAIN_LEN-1:1]};
            bitcnt_q <= bitcnt_q - BW'(1);
            phcnt_q  <= PH_LAST;
            state_q  <= (bitcnt_q == BW'(1)) ? FINISH : SHIFT_LO;
          end else begin
            phcnt_q <= phcnt_q - 4'd1;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scan_clk          = scan_clk_q;
  assign scan_en           = scan_en_q;
  assign scan_in           = scan_in_q;
  assign host.busy         = busy_q;
  assign host.done         = done_q;
  assign host.capture_data = capture_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl: two instances (8-bit/HALF=1 and
// 24-bit/HALF=3) driving behavioural scan-chain models.
module tb_scan_ctrl;
  import scan_pkg::*;

  localparam int LA = 8;
  localparam int HA = 1;
  localparam int LB = 24;
  localparam int HB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_ctrl_if #(.CHAIN_LEN(LA)) ifa ();
  scan_ctrl_if #(.CHAIN_LEN(LB)) ifb ();

  logic sclk_a, sen_a, sin_a, sout_a;
  logic sclk_b, sen_b, sin_b, sout_b;

  scan_ctrl #(.CHAIN_LEN(LA), .HALF(HA)) u_a (
    .clk(clk), .rst_n(rst_n), .host(ifa.slave),
    .scan_clk(sclk_a), .scan_en(sen_a), .scan_in(sin_a), .scan_out(sout_a)
  );
  scan_ctrl #(.CHAIN_LEN(LB), .HALF(HB)) u_b (
    .clk(clk), .rst_n(rst_n), .host(ifb.slave),
    .scan_clk(sclk_b), .scan_en(sen_b), .scan_in(sin_b), .scan_out(sout_b)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scan-chain models (tail = bit 0) ----------------
  logic [LA-1:0] chain_a;
  logic [LA-1:0] pre_val_a;
  logic          pre_a = 1'b0;
  int            edges_a = 0;
  logic          sin_hist_a;
  logic [LB-1:0] chain_b;
  logic [LB-1:0] pre_val_b;
  logic          pre_b = 1'b0;
  int            edges_b = 0;
  logic          sin_hist_b;

  assign sout_a = chain_a[0];
  assign sout_b = chain_b[0];

  always @(posedge sclk_a or posedge pre_a) begin
    if (pre_a) chain_a <= pre_val_a;
    else begin
      chain_a <= {sin_a, chain_a[LA-1:1]};
      edges_a <= edges_a + 1;
      chk("en_at_rise_a", 64'(sen_a), 64'd1);
      chk("sin_stable_a", 64'(sin_a), 64'(sin_hist_a));
    end
  end
  always @(posedge sclk_b or posedge pre_b) begin
    if (pre_b) chain_b <= pre_val_b;
    else begin
      chain_b <= {sin_b, chain_b[LB-1:1]};
      edges_b <= edges_b + 1;
      chk("en_at_rise_b", 64'(sen_b), 64'd1);
      chk("sin_stable_b", 64'(sin_b), 64'(sin_hist_b));
    end
  end
  always @(negedge clk) sin_hist_a <= sin_a;
  always @(negedge clk) sin_hist_b <= sin_b;

  // Scan clock phase widths on instance B: every high phase and every low
  // phase between two highs must last exactly HB cycles.
  int   run_b = 0;
  logic prev_b = 1'b0;
  bit   hi_seen_b = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || !ifb.busy) begin
      run_b <= 0; prev_b <= 1'b0; hi_seen_b <= 1'b0;
    end else if (sclk_b != prev_b) begin
      if (prev_b || hi_seen_b) chk("phase_b", 64'(run_b), 64'(HB));
      if (prev_b) hi_seen_b <= 1'b1;
      prev_b <= sclk_b;
      run_b  <= 1;
    end else begin
      run_b <= run_b + 1;
    end
  end

  // ---------------- accessors ----------------
  function automatic logic [63:0] o_cap(input int s);
    return (s == 0) ? 64'(ifa.capture_data) : 64'(ifb.capture_data);
  endfunction
  function automatic logic o_done(input int s);
    return (s == 0) ? ifa.done : ifb.done;
  endfunction
  function automatic logic o_busy(input int s);
    return (s == 0) ? ifa.busy : ifb.busy;
  endfunction
  function automatic logic [63:0] o_chain(input int s);
    return (s == 0) ? 64'(chain_a) : 64'(chain_b);
  endfunction
  function automatic int o_edges(input int s);
    return (s == 0) ? edges_a : edges_b;
  endfunction

  task automatic drive(input int s, input logic st, input logic [63:0] d);
    if (s == 0) begin ifa.start = st; ifa.load_data = d[LA-1:0]; end
    else        begin ifb.start = st; ifb.load_data = d[LB-1:0]; end
  endtask

  logic [63:0] exp_chain [2];

  task automatic preload(input int s, input logic [63:0] d);
    if (s == 0) begin pre_val_a = d[LA-1:0]; pre_a = 1'b1; #1 pre_a = 1'b0; end
    else        begin pre_val_b = d[LB-1:0]; pre_b = 1'b1; #1 pre_b = 1'b0; end
    exp_chain[s] = d & ((64'd1 << ((s == 0) ? LA : LB)) - 64'd1);
  endtask

  // One transaction; returns in the cycle where done is visible. With ign
  // set, start is held high through the whole busy window (must be ignored).
  task automatic txn(input int s, input logic [63:0] d, input bit ign);
    int L, H, lat, e0;
    bit got;
    logic [63:0] mask, cap_exp;
    L = (s == 0) ? LA : LB;
    H = (s == 0) ? HA : HB;
    mask = (64'd1 << L) - 64'd1;
    cap_exp = exp_chain[s];
    e0 = o_edges(s);
    drive(s, 1'b1, d);
    @(posedge clk); #1;
    drive(s, 1'b0, {$urandom, $urandom});
    chk("busy_gap", 64'(o_busy(s)), 64'd0);
    lat = 0; got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) chk("busy_rise", 64'(o_busy(s)), 64'd1);
      if (o_done(s)) got = 1'b1;
      else drive(s, ign | ($urandom_range(0, 3) == 0), {$urandom, $urandom});
    end
    drive(s, 1'b0, d);
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    chk("latency", 64'(lat), 64'(2 + 2 * H * L));
    chk("capture", o_cap(s), cap_exp);
    chk("chain_load", o_chain(s), d & mask);
    chk("edge_count", 64'(o_edges(s) - e0), 64'(L));
    exp_chain[s] = d & mask;
  endtask

  initial begin
    int e0, n, gap;
    logic acc;
    logic [63:0] d;

    drive(0, 1'b0, 64'd0);
    drive(1, 1'b0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(ifa.busy | ifb.busy), 64'd0);
    chk("rst_done", 64'(ifa.done | ifb.done), 64'd0);
    chk("rst_cap_a", 64'(ifa.capture_data), 64'd0);
    chk("rst_cap_b", 64'(ifb.capture_data), 64'd0);
    chk("rst_pins", 64'({sclk_a, sen_a, sin_a, sclk_b, sen_b, sin_b}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    preload(0, 64'hA5);
    preload(1, {$urandom, $urandom});
    @(posedge clk); #1;

    // Load/capture with start held high throughout busy (ignored).
    txn(0, 64'h3C, 1'b1);
    @(posedge clk); #1;
    chk("done_one_pulse", 64'(ifa.done), 64'd0);
    chk("no_requeue_busy", 64'(ifa.busy), 64'd0);
    e0 = edges_a;
    repeat (4) @(posedge clk);
    #1;
    chk("no_extra_edges", 64'(edges_a - e0), 64'd0);

    // Round trip, back-to-back in the first idle cycle.
    txn(0, 64'hFF, 1'b0);
    txn(0, 64'h00, 1'b0);

    // Random transactions with random gaps (0 = back-to-back).
    for (int i = 0; i < 6; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      txn(0, {$urandom, $urandom}, ($urandom_range(0, 1) == 1));
    end

    // HALF=3, 24-bit chain.
    @(posedge clk); #1;
    txn(1, 64'h5A5A5A, 1'b0);
    @(posedge clk); #1;
    txn(1, {$urandom, $urandom}, 1'b0);

    // Reset in the middle of shifting.
    @(posedge clk); #1;
    e0 = edges_a;
    drive(0, 1'b1, 64'h96);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'h96);
    n = 0;
    while ((edges_a - e0) < 4 && n < 100) begin @(posedge clk); #1; n++; end
    chk("mid_edges_reached", 64'(edges_a - e0), 64'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sclk", 64'(sclk_a), 64'd0);
    chk("mid_rst_sen", 64'(sen_a), 64'd0);
    chk("mid_rst_busy", 64'(ifa.busy), 64'd0);
    chk("mid_rst_done", 64'(ifa.done), 64'd0);
    chk("mid_rst_cap", 64'(ifa.capture_data), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    d = {$urandom, $urandom};
    preload(0, d);
    @(posedge clk); #1;
    txn(0, 64'hC3, 1'b0);

    // Idle quiet.
    acc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      acc = acc | sclk_a | sen_a | sin_a | ifa.done | sclk_b | sen_b | sin_b | ifb.done;
    end
    chk("idle_quiet", 64'(acc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
- Sequencer driving the toy CPU's scan chain (scan_clk, scan_en, scan_in / scan_out) from the system clock.
- Sits upstream of the CPU core and replaces the hand-toggled scan pins.
- One transaction does two things at once:
  - shifts a CHAIN_LEN-bit parallel word into the chain;
  - captures the chain's previous contents into a parallel register.
- Used for state load/readout and for debug of the core.

Parameters:
- CHAIN_LEN, 24, number of flops in the CPU scan chain; legal range 2..64.
- HALF, 2, system-clock cycles per scan_clk phase (low and high); legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled in IDLE only
- load_data  input  CHAIN_LEN  word to shift in; latched on the accepted start
- busy  output  1  high from the cycle after an accepted start through FINISH
- done  output  1  one-cycle pulse in FINISH
- capture_data  output  CHAIN_LEN  previous chain contents; valid from done, held until the next done
- scan_clk  output  1  scan clock to the CPU
- scan_en  output  1  scan enable to the CPU
- scan_in  output  1  serial data into the chain
- scan_out  input  1  serial data from the chain tail

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- All outputs are registered.
- Reset values: busy=0, done=0, capture_data=0, scan_clk=0, scan_en=0, scan_in=0, state=IDLE, internal shift register sr=0.
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, FINISH.
- IDLE:
  - start=1 → sr<=load_data, bitcnt<=CHAIN_LEN, phcnt<=HALF-1, go to SETUP.
  - Otherwise remain in IDLE.
- SETUP (1 cycle): scan_en=1, scan_clk=0, scan_in=sr[0], busy=1; then go to SHIFT_LO.
- SHIFT_LO (HALF cycles):
  - scan_clk=0, scan_en=1, scan_in=sr[0].
  - On the last cycle (phcnt==0), sample scan_out into cap_bit.
  - Then go to SHIFT_HI with phcnt reloaded to HALF-1.
- SHIFT_HI (HALF cycles):
  - scan_clk=1; scan_in held stable.
  - On the last cycle: sr<={cap_bit, sr[CHAIN_LEN-1:1]}, bitcnt<=bitcnt-1.
  - If bitcnt was 1, go to FINISH; else go to SHIFT_LO with phcnt reloaded.
- FINISH (1 cycle):
  - scan_en=0, scan_clk=0, done=1, capture_data<=sr, busy=1.
  - Then go to IDLE with busy=0.
- Bit order: LSB of load_data enters the chain first. capture_data[0] is the first bit emerging from scan_out.
- Timing:
  - scan_in changes only while scan_clk=0 and at least one cycle before the rising edge.
  - The rising scan_clk occurs at the SHIFT_LO→SHIFT_HI transition.
- Latency: done asserts exactly 2 + 2*HALF*CHAIN_LEN cycles after the edge at which start was accepted.
- Exactly CHAIN_LEN rising edges of scan_clk occur per transaction, all with scan_en=1.
- start outside IDLE (including in FINISH) is ignored; it is not queued. load_data changes during busy have no effect.
- Back-to-back: start in the first IDLE cycle after FINISH is accepted. Minimum turnaround is 1 IDLE cycle.
- rst_n asserted mid-transaction:
  - Immediately forces scan_clk=0, scan_en=0, busy=0, done=0, capture_data=0.
  - The CPU chain contents are then undefined; software reissues the transaction.
- Counter widths: bitcnt = $clog2(CHAIN_LEN+1); phcnt = 4 bits. No wrap is possible within legal ranges.
- Elaboration-time assertions check the legal ranges of CHAIN_LEN and HALF.

Decomposition:
- Package scan_pkg holds:
  - state enum scan_state_e {IDLE, SETUP, SHIFT_LO, SHIFT_HI, FINISH};
  - constants SCAN_CHAIN_LEN_DEFAULT=24 and SCAN_HALF_DEFAULT=2, shared with the CPU top and the bench.
- Single module; no sub-module. The phase counter is too small to justify one.

Test Plan:
- Load/capture: CHAIN_LEN=8, HALF=1, bench chain model preloaded 8'hA5; start with load_data=8'h3C → done at cycle 18, capture_data=8'hA5, model=8'h3C, exactly 8 scan_clk rising edges.
- Round trip: load 8'hFF, then immediately load 8'h00 (start in first IDLE cycle) → second capture_data=8'hFF; busy low for exactly 1 cycle between transactions.
- Ignored start: pulse start in SHIFT_HI and in FINISH cycles → no extra transaction; edge count stays 8; done pulses once.
- HALF=3, CHAIN_LEN=24, load 24'h5A5A5A → done after 2+144=146 cycles; scan_clk high and low phases each exactly 3 cycles; scan_in stable across every rising edge.
- Reset mid-shift: assert rst_n=0 after 4 scan_clk edges → same cycle scan_clk=0, scan_en=0, busy=0; after release, a new start completes normally with correct capture.
- Idle quiet: 100 cycles with no start → scan_clk, scan_en, scan_in constant 0; done never asserts.
